// File: rtl/spi_adar7251_40bit_slave.sv
// 40-bit ADAR7251-format SPI register slave (mode 0), oversampled on i_clk.
// Optional macro SPI_SLV_SDO_OE_EN: SDO enable only during read data bits.
module spi_adar7251_40bit_slave #(
    parameter logic [6:0] CHIP_ADDR = 7'h00,
    parameter int         REG_AW    = 4
) (
    input  logic        i_clk,
    input  logic        i_reset_n,
    input  logic        i_spi_sclk,
    input  logic        i_spi_csb,
    input  logic        i_spi_sdi,
    output logic        o_spi_sdo,
    output logic        o_spi_sdo_oe,
    output logic        o_wr_valid,
    output logic [15:0] o_wr_addr,
    output logic [15:0] o_wr_data,
    output logic        o_busy,
    output logic        o_frame_err
);
    typedef enum logic [2:0] {S_IDLE, S_HEADER, S_DATA, S_DONE, S_SKIP} state_t;

    state_t      r_state, w_state_nxt;
    logic [2:0]  r_sclk_s, r_csb_s;
    logic [1:0]  r_sdi_s;
    logic [5:0]  r_cnt;
    logic [15:0] r_shift, r_addr, r_tx;
    logic        r_rd, r_tx_act, r_sdo, r_wr_valid, r_frame_err;
    logic [15:0] r_wr_addr, r_wr_data;
    logic [15:0] r_regs [2**REG_AW];

    logic        w_sclk_rise, w_sclk_fall, w_csb_fall, w_csb_rise;
    logic        w_sample, w_hdr_done, w_last, w_err;
    logic [15:0] w_word, w_rd_word;
    logic        w_word_in_range, w_addr_in_range;

    assign w_sclk_rise = r_sclk_s[1] & ~r_sclk_s[2];
    assign w_sclk_fall = ~r_sclk_s[1] & r_sclk_s[2];
    assign w_csb_fall  = ~r_csb_s[1] & r_csb_s[2];
    assign w_csb_rise  = r_csb_s[1] & ~r_csb_s[2];

    // Word completed by the current sample: reg_addr on the 24th, reg_data on the 40th.
    assign w_word          = {r_shift[14:0], r_sdi_s[1]};
    assign w_word_in_range = (w_word >> REG_AW) == 16'd0;
    assign w_addr_in_range = (r_addr >> REG_AW) == 16'd0;
    assign w_rd_word       = w_word_in_range ? r_regs[w_word[REG_AW-1:0]] : 16'h0000;

    // CSB sync resets low so a CSB already low at release is not seen as a fall.
    always_ff @(posedge i_clk or negedge i_reset_n) begin
        if (!i_reset_n) begin
            r_sclk_s <= '0;
            r_csb_s  <= '0;
            r_sdi_s  <= '0;
            r_state  <= S_IDLE;
        end else begin
            r_sclk_s <= {r_sclk_s[1:0], i_spi_sclk};
            r_csb_s  <= {r_csb_s[1:0], i_spi_csb};
            r_sdi_s  <= {r_sdi_s[0], i_spi_sdi};
            r_state  <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_sample    = 1'b0;
        w_hdr_done  = 1'b0;
        w_last      = 1'b0;
        w_err       = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (w_csb_fall) w_state_nxt = S_HEADER;
            end
            S_HEADER: begin
                if (w_sclk_rise) begin
                    w_sample = 1'b1;
                    if (r_cnt == 6'd7 && r_shift[6:0] != CHIP_ADDR) begin
                        w_state_nxt = S_SKIP;
                    end else if (r_cnt == 6'd23) begin
                        w_state_nxt = S_DATA;
                        w_hdr_done  = 1'b1;
                    end
                end
                if (w_csb_rise) begin
                    w_state_nxt = S_IDLE;
                    w_hdr_done  = 1'b0;
                    w_err       = 1'b1;
                end
            end
            S_DATA: begin
                // The sample is taken before a coincident CSB rise is honoured.
                if (w_sclk_rise) begin
                    w_sample = 1'b1;
                    if (r_cnt == 6'd39) begin
                        w_state_nxt = S_DONE;
                        w_last      = 1'b1;
                    end
                end
                if (w_csb_rise) begin
                    w_state_nxt = S_IDLE;
                    w_err       = ~w_last;
                end
            end
            S_DONE, S_SKIP: begin
                if (w_csb_rise) w_state_nxt = S_IDLE;
            end
            default: w_state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge i_clk or negedge i_reset_n) begin
        if (!i_reset_n) begin
            r_cnt       <= '0;
            r_shift     <= '0;
            r_addr      <= '0;
            r_tx        <= '0;
            r_rd        <= 1'b0;
            r_tx_act    <= 1'b0;
            r_sdo       <= 1'b0;
            r_wr_valid  <= 1'b0;
            r_wr_addr   <= '0;
            r_wr_data   <= '0;
            r_frame_err <= 1'b0;
            for (int i = 0; i < 2**REG_AW; i++) r_regs[i] <= 16'h0000;
        end else begin
            r_wr_valid  <= 1'b0;
            r_frame_err <= w_err;
            if (r_state == S_IDLE) r_cnt <= '0;
            else if (w_sample)     r_cnt <= r_cnt + 6'd1;
            if (w_sample) r_shift <= w_word;
            if (w_hdr_done) begin
                r_rd   <= r_shift[15];
                r_addr <= w_word;
                if (r_shift[15]) begin
                    r_tx     <= w_rd_word;
                    r_tx_act <= 1'b1;
                end
            end
            if (r_state == S_DATA && w_sclk_fall && r_tx_act) begin
                r_sdo <= r_tx[15];
                r_tx  <= {r_tx[14:0], 1'b0};
            end
            if (w_last) begin
                r_sdo    <= 1'b0;
                r_tx_act <= 1'b0;
                if (!r_rd) begin
                    r_wr_valid <= 1'b1;
                    r_wr_addr  <= r_addr;
                    r_wr_data  <= w_word;
                    if (w_addr_in_range) r_regs[r_addr[REG_AW-1:0]] <= w_word;
                end
            end
            if (r_state != S_IDLE && w_state_nxt == S_IDLE) begin
                r_sdo    <= 1'b0;
                r_tx_act <= 1'b0;
            end
        end
    end

`ifdef SPI_SLV_SDO_OE_EN
    logic r_oe;
    always_ff @(posedge i_clk or negedge i_reset_n) begin
        if (!i_reset_n) begin
            r_oe <= 1'b0;
        end else if (r_state != S_IDLE && w_state_nxt == S_IDLE) begin
            r_oe <= 1'b0;
        end else if (r_state == S_DATA && w_sclk_fall && r_tx_act) begin
            r_oe <= 1'b1;
        end
    end
    assign o_spi_sdo_oe = r_oe;
`else
    assign o_spi_sdo_oe = 1'b1;
`endif

    assign o_spi_sdo   = r_sdo;
    assign o_wr_valid  = r_wr_valid;
    assign o_wr_addr   = r_wr_addr;
    assign o_wr_data   = r_wr_data;
    assign o_busy      = (r_state != S_IDLE);
    assign o_frame_err = r_frame_err;
endmodule
